// File: rtl/icache_refill.sv
// Instruction-cache miss refill: wins the byte-wide bus, reads four bytes at A..A+3,
// and writes the little-endian instruction into the icache in one cycle.
module icache_refill #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic              flush_i,
  input  logic              gnt_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic              mem_wr_o,
  input  logic [7:0]        mem_din_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [31:0]       winst_o,
  output logic              done_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic                mem_req_s;
  logic                accept_s;
  logic [2:0]          cnt_r;
  logic [ADDR_W-1:0]   a_r;
  logic [ADDR_W-1:0]   mem_a_r;
  logic [7:0]          b0_r;
  logic [7:0]          b1_r;
  logic [7:0]          b2_r;
  logic                we_r;
  logic                done_r;
  logic [ADDR_W-1:0]   waddr_r;
  logic [31:0]         winst_r;

  // Next-state and bus-request decode.
  always_comb begin
    state_s   = state_r;
    mem_req_s = 1'b0;
    accept_s  = 1'b0;
    case (state_r)
      IDLE: begin
        mem_req_s = req_i;
        if (req_i && gnt_i && !flush_i) begin
          state_s  = RD;
          accept_s = 1'b1;
        end else begin
          state_s  = IDLE;
        end
      end
      RD: begin
        mem_req_s = 1'b1;
        if (flush_i) begin
          state_s = IDLE;
        end else if (cnt_r == 3'd4) begin
          state_s = WB;
        end else begin
          state_s = RD;
        end
      end
      WB: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register; rdy low freezes the engine.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else if (rdy) begin
      state_r <= state_s;
    end else begin
      state_r <= state_r;
    end
  end

  // Address sequencing, byte capture and the registered icache write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= 3'd0;
      a_r     <= {ADDR_W{1'b0}};
      mem_a_r <= {ADDR_W{1'b0}};
      b0_r    <= 8'h00;
      b1_r    <= 8'h00;
      b2_r    <= 8'h00;
      we_r    <= 1'b0;
      done_r  <= 1'b0;
      waddr_r <= {ADDR_W{1'b0}};
      winst_r <= 32'h0000_0000;
    end else if (rdy) begin
      we_r    <= 1'b0;
      done_r  <= 1'b0;
      waddr_r <= {ADDR_W{1'b0}};
      winst_r <= 32'h0000_0000;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r     <= req_addr_i;
            mem_a_r <= req_addr_i;
            cnt_r   <= 3'd0;
          end
        end
        RD: begin
          if (cnt_r < 3'd3) begin
            mem_a_r <= a_r + ADDR_W'(cnt_r) + ADDR_W'(1);
          end
          // The fourth byte goes straight into the write register.
          case (cnt_r)
            3'd1:    b0_r <= mem_din_i;
            3'd2:    b1_r <= mem_din_i;
            3'd3:    b2_r <= mem_din_i;
            default: b0_r <= b0_r;
          endcase
          cnt_r <= (cnt_r == 3'd4) ? 3'd0 : cnt_r + 3'd1;
          if ((cnt_r == 3'd4) && !flush_i) begin
            we_r    <= 1'b1;
            done_r  <= 1'b1;
            waddr_r <= a_r;
            winst_r <= {mem_din_i, b2_r, b1_r, b0_r};
          end
        end
        WB: begin
          cnt_r <= 3'd0;
        end
        default: begin
          cnt_r <= 3'd0;
        end
      endcase
    end
  end

  assign mem_req_o = rst ? 1'b0 : mem_req_s;
  assign mem_a_o   = mem_a_r;
  assign mem_wr_o  = 1'b0;
  assign we_o      = we_r;
  assign done_o    = done_r;
  assign waddr_o   = waddr_r;
  assign winst_o   = winst_r;
  assign busy_o    = (state_r != IDLE);

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill with a behavioural byte memory (one-cycle read, frozen by rdy).
module tb_icache_refill;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        req_i;
  logic [31:0] req_addr_i;
  logic        flush_i;
  logic        gnt_i;
  logic        mem_req_o;
  logic [31:0] mem_a_o;
  logic        mem_wr_o;
  logic [7:0]  mem_din_i;
  logic        we_o;
  logic [31:0] waddr_o;
  logic [31:0] winst_o;
  logic        done_o;
  logic        busy_o;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] mem [logic [31:0]];

  icache_refill #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .req_i      (req_i),
    .req_addr_i (req_addr_i),
    .flush_i    (flush_i),
    .gnt_i      (gnt_i),
    .mem_req_o  (mem_req_o),
    .mem_a_o    (mem_a_o),
    .mem_wr_o   (mem_wr_o),
    .mem_din_i  (mem_din_i),
    .we_o       (we_o),
    .waddr_o    (waddr_o),
    .winst_o    (winst_o),
    .done_o     (done_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rd_mem(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  always @(posedge clk) begin
    if (rdy) mem_din_i <= rd_mem(mem_a_o);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load4(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem[a + 32'(i)] = w[8*i +: 8];
  endtask

  // Drives C0 (request with grant) and checks C1..C7 of a full refill.
  task automatic run_refill(input string tag, input logic [31:0] a, input logic [31:0] w,
                            input bit flush_in_wb);
    req_i = 1'b1; gnt_i = 1'b1; req_addr_i = a;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk({tag, "_mem_a"}, mem_a_o, a + 32'((k < 5) ? k - 1 : 3));
      chk({tag, "_busy_rd"}, busy_o, 1'b1);
      chk({tag, "_mem_req_rd"}, mem_req_o, 1'b1);
      chk({tag, "_we_early"}, we_o, 1'b0);
    end
    tick();
    if (flush_in_wb) flush_i = 1'b1;
    chk({tag, "_we"}, we_o, 1'b1);
    chk({tag, "_done"}, done_o, 1'b1);
    chk({tag, "_waddr"}, waddr_o, a);
    chk({tag, "_winst"}, winst_o, w);
    chk({tag, "_busy_wb"}, busy_o, 1'b1);
    req_i = 1'b0;
    tick();
    flush_i = 1'b0;
    chk({tag, "_we_after"}, we_o, 1'b0);
    chk({tag, "_done_after"}, done_o, 1'b0);
    chk({tag, "_waddr_after"}, waddr_o, 32'h0);
    chk({tag, "_winst_after"}, winst_o, 32'h0);
    chk({tag, "_busy_after"}, busy_o, 1'b0);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; req_i = 1'b0; req_addr_i = 32'h0; flush_i = 1'b0; gnt_i = 1'b0;
    load4(32'h0000_1000, 32'h0000_0513);
    load4(32'h0000_2000, 32'h0010_0093);
    load4(32'h0000_3000, 32'h0000_4137);
    load4(32'h0000_4000, 32'h00a5_2023);
    load4(32'h0000_5000, 32'hdead_beef);
    load4(32'hFFFF_FFFC, 32'h0000_00EF);

    // Power-on reset
    tick(); tick();
    chk("rst_mem_a", mem_a_o, 32'h0);
    chk("rst_we", we_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_mem_req", mem_req_o, 1'b0);
    chk("rst_mem_wr", mem_wr_o, 1'b0);
    chk("rst_waddr", waddr_o, 32'h0);
    chk("rst_winst", winst_o, 32'h0);
    rst = 1'b0;

    // Grant stall for 3 cycles, then basic refill
    req_i = 1'b1; gnt_i = 1'b0; req_addr_i = 32'h0000_1000;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_mem_a", mem_a_o, 32'h0);
      chk("stall_busy", busy_o, 1'b0);
      chk("stall_mem_req", mem_req_o, 1'b1);
    end
    run_refill("basic", 32'h0000_1000, 32'h0000_0513, 1'b0);

    // Reset in the middle of a refill
    req_i = 1'b1; gnt_i = 1'b1; req_addr_i = 32'h0000_3000;
    tick(); tick();
    chk("midrst_busy_pre", busy_o, 1'b1);
    rst = 1'b1; req_i = 1'b0;
    tick(); tick();
    chk("midrst_mem_a", mem_a_o, 32'h0);
    chk("midrst_busy", busy_o, 1'b0);
    chk("midrst_we", we_o, 1'b0);
    chk("midrst_mem_req", mem_req_o, 1'b0);
    chk("midrst_winst", winst_o, 32'h0);
    rst = 1'b0;
    run_refill("after_rst", 32'h0000_3000, 32'h0000_4137, 1'b0);

    // Flush at cnt=2 (C3)
    req_i = 1'b1; gnt_i = 1'b1; req_addr_i = 32'h0000_5000;
    tick(); tick(); tick();
    chk("flush_mem_a_c3", mem_a_o, 32'h0000_5002);
    flush_i = 1'b1; req_i = 1'b0;
    tick();
    flush_i = 1'b0;
    chk("flush_busy", busy_o, 1'b0);
    chk("flush_mem_req", mem_req_o, 1'b0);
    for (int k = 0; k < 10; k++) begin
      chk("flush_no_we", we_o, 1'b0);
      tick();
    end
    run_refill("post_flush", 32'h0000_2000, 32'h0010_0093, 1'b0);

    // rdy low for 2 cycles at cnt=2
    req_i = 1'b1; gnt_i = 1'b1; req_addr_i = 32'h0000_4000;
    tick(); tick(); tick();
    chk("rdy_mem_a_c3", mem_a_o, 32'h0000_4002);
    rdy = 1'b0;
    tick();
    chk("rdy_hold1", mem_a_o, 32'h0000_4002);
    chk("rdy_busy1", busy_o, 1'b1);
    tick();
    chk("rdy_hold2", mem_a_o, 32'h0000_4002);
    rdy = 1'b1;
    tick();
    chk("rdy_mem_a_c6", mem_a_o, 32'h0000_4003);
    tick();
    chk("rdy_we_c7", we_o, 1'b0);
    tick();
    chk("rdy_we_c8", we_o, 1'b1);
    chk("rdy_winst", winst_o, 32'h00a5_2023);
    chk("rdy_waddr", waddr_o, 32'h0000_4000);
    req_i = 1'b0;
    tick();
    chk("rdy_we_c9", we_o, 1'b0);

    // High address with flush during WB
    run_refill("high", 32'hFFFF_FFFC, 32'h0000_00EF, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_refill.md
# icache_refill

Miss-refill engine that fills the instruction cache. When the fetch stage reports an icache miss, this block wins the byte-wide memory bus from the arbiter and reads four consecutive bytes. It assembles them little-endian into one instruction, then writes the instruction into the icache through the cache's write port in a single-cycle write. It sits between IF, the memory arbiter and the icache, and is the only writer of the icache.

## Interface
- `ADDR_W`, default 32, width of instruction addresses and memory address.
- `clk` input, 1 bit, clock.
- `rst` input, 1 bit, synchronous, active-high reset.
- `rdy` input, 1 bit, global ready; low freezes all state, and memory is frozen with it.
- `req_i` input, 1 bit, IF miss request; held high until `done_o`.
- `req_addr_i` input, `ADDR_W` bits, miss address A, used unmodified with no alignment check.
- `flush_i` input, 1 bit, branch-mispredict abort.
- `gnt_i` input, 1 bit, bus grant from the arbiter; sampled only in IDLE.
- `mem_req_o` output, 1 bit, bus request to the arbiter.
- `mem_a_o` output, `ADDR_W` bits, registered memory byte address.
- `mem_wr_o` output, 1 bit, always 0 (read only).
- `mem_din_i` input, 8 bits, read data.
- `we_o` output, 1 bit, icache write enable, one cycle.
- `waddr_o` output, `ADDR_W` bits, icache write address.
- `winst_o` output, 32 bits, icache write instruction.
- `done_o` output, 1 bit, pulses together with `we_o`.
- `busy_o` output, 1 bit, high in RD or WB.

## Operation
- Memory contract: `mem_din_i` in cycle n+1 is the byte M[`mem_a_o` in cycle n].
- States: IDLE, RD, WB. There is a 3-bit counter `cnt`, 0..4, and byte registers `b0`..`b3`.
- IDLE:
  - `mem_req_o` = `req_i`, combinational.
  - If `req_i` && `gnt_i` && !`flush_i`: latch A, set `mem_a_o` <= A, `cnt` <= 0, go to RD.
- RD, each cycle:
  - If `cnt` < 3: `mem_a_o` <= A+`cnt`+1, computed mod 2^ADDR_W.
  - If `cnt` >= 1: `b[cnt-1]` <= `mem_din_i`.
  - `cnt` <= `cnt`+1.
  - At `cnt` == 4: go to WB.
  - `mem_req_o` = 1 throughout RD.
- WB, one cycle:
  - `we_o` = 1, `done_o` = 1, `waddr_o` = A, `winst_o` = {b3,b2,b1,b0}.
  - Next state is IDLE.
  - `we_o`, `waddr_o`, `winst_o` and `done_o` are registered. Outside WB they are 0.
- `flush_i` in RD: go to IDLE next cycle, drop `mem_req_o`, and issue no write.
- `flush_i` in WB: ignored. The write completes because the data is valid memory content, and IF discards `done_o`.
- `req_i` outside IDLE is ignored. There is no queueing.
- `rdy` low: state, counter, byte registers and all registered outputs hold. Combinational `mem_req_o` still follows its state.
- `rst` has priority over everything, including in the middle of a refill.
- Reset values:
  - State IDLE, `cnt` 0.
  - `mem_a_o`, `waddr_o`, `winst_o` and `b0`..`b3` are 0.
  - `we_o`, `done_o`, `busy_o`, `mem_req_o` and `mem_wr_o` are 0.

## Timing
- C0 is the IDLE cycle in which `req_i`, `gnt_i` and `rdy` are all high.
- C1..C5: RD with `cnt` = 0..4.
  - `mem_a_o` = A, A+1, A+2, A+3, then A+3 held in C5.
  - Bytes are captured at the ends of C2..C5.
- C6: WB, with `we_o` and `done_o` high.
- C7: IDLE. This is the earliest cycle in which the next request can be accepted.
- Latency is 6 cycles from acceptance to write. Each `rdy`-low cycle adds exactly one cycle.
- If `gnt_i` is low in IDLE, nothing is issued and the block retries every cycle.
- The icache forwards write data to a read in the same cycle, so IF sees a hit in C6.

## Test plan
- Reset: assert `rst` for 2 cycles mid-RD. All outputs are 0 and the state is IDLE. The next request completes in 6 cycles.
- Basic refill:
  - Stimulus: A=0x00001000, M = 13,05,00,00.
  - `mem_a_o` sequence is 0x1000, 0x1001, 0x1002, 0x1003 in C1..C4.
  - In C6: `we_o`=1, `waddr_o`=0x1000, `winst_o`=0x00000513, `done_o`=1.
- Grant stall: `req_i` is high with `gnt_i` low for 3 cycles. `mem_a_o` stays 0 and `busy_o` stays 0. The write lands 6 cycles after `gnt_i` rises.
- Flush: `flush_i` arrives at `cnt`=2.
  - Next cycle: IDLE, `mem_req_o`=0, and no `we_o` in the following 10 cycles.
  - A new request with A=0x2000 then writes correct data.
- `rdy` pause: `rdy` is low for 2 cycles at `cnt`=2. `mem_a_o` and `cnt` hold, and the write appears in C8 with the correct instruction.
- High address: A=0xFFFFFFFC, M = EF,00,00,00. `mem_a_o` runs 0xFFFFFFFC..0xFFFFFFFF and `winst_o`=0x000000EF. A `flush_i` in WB does not suppress `we_o`.
